hsi_lane_engine: RTL and testbench
==================================

HSI_LANE_ENGINE -- requirements
Module: hsi_lane_engine

Interface
REQ-001 SHALL have parameter NUM_TX, default 3, number of TX stream channels (legal 1..8).
REQ-002 SHALL have parameter DATA_W, default 32, stream word width (legal 8..64).
REQ-003 SHALL have parameter DIV, default 2, clk cycles per serial half-bit (legal 1..255).
REQ-004 SHALL have ports, in this order: clk in 1 (sole clock); rstn in 1 (reset, asynchronous, active-low).
REQ-005 SHALL have port cfg_enable in 1: permits new word starts.
REQ-006 SHALL have ports s_tdata in NUM_TX*DATA_W, s_tvalid in NUM_TX, s_tready out NUM_TX: TX AXI-stream channels, channel i in slice i.
REQ-007 SHALL have ports m_tdata out DATA_W, m_tvalid out 1, m_tready in 1: RX AXI-stream output.
REQ-008 SHALL have ports hs_clk out 1 (serial clock), hs_frame out 1 (word envelope), hs_tx out 1 (serial data out), hs_rx in 1 (serial data in).
REQ-009 SHALL have ports busy out 1 (state not IDLE) and rx_overflow out 1 (sticky drop flag).

Function
REQ-010 SHALL define CH_W = max(1, clog2(NUM_TX)) and bit period = 2*DIV clk cycles.
REQ-011 SHALL implement states IDLE, HDR, DATA, GAP.
REQ-012 In IDLE with cfg_enable=1 and any s_tvalid=1, SHALL grant one channel round-robin, searching from (last granted+1) mod NUM_TX; first grant after reset searches from channel 0.
REQ-013 SHALL assert s_tready of the granted channel for exactly that one cycle, latch its s_tdata, and enter HDR on the next cycle; s_tready SHALL be 0 at all other times.
REQ-014 SHALL transmit CH_W header bits (granted channel index) MSB first in HDR, then DATA_W data bits MSB first in DATA, then exactly one bit period in GAP, then return to IDLE.
REQ-015 hs_frame SHALL be 1 throughout HDR and DATA and 0 in IDLE and GAP; the first hs_frame=1 cycle SHALL follow the s_tready cycle directly.
REQ-016 During HDR/DATA, hs_clk SHALL be 0 for the first DIV cycles of each bit and 1 for the last DIV; it SHALL be 0 in IDLE and GAP.
REQ-017 hs_tx SHALL change only at bit start and SHALL be 0 outside HDR/DATA.
REQ-018 SHALL sample hs_rx on the clk cycle where hs_clk rises, during DATA bits only (not HDR), shifting MSB first.
REQ-019 On GAP entry, SHALL load the captured word into m_tdata and set m_tvalid=1 if m_tvalid=0, or if m_tvalid=1 and m_tready=1 in that same cycle.
REQ-020 Otherwise, on GAP entry with m_tvalid=1 and m_tready=0, SHALL drop the word, keep m_tdata unchanged, and set rx_overflow=1.
REQ-021 rx_overflow SHALL remain 1 until reset.
REQ-022 m_tvalid SHALL clear on m_tvalid&m_tready unless a new word loads in the same cycle.
REQ-023 cfg_enable falling mid-word SHALL NOT abort; the word SHALL complete through GAP, then stay IDLE.
REQ-024 Word time SHALL be exactly 1 + (CH_W+DATA_W+1)*2*DIV cycles, from s_tready to the next possible s_tready; back-to-back words SHALL achieve this.

Reset
REQ-025 rstn=0 SHALL asynchronously force: state IDLE; s_tready, hs_clk, hs_frame, hs_tx, busy, m_tvalid, rx_overflow = 0; m_tdata = 0; arbiter pointer = 0.
REQ-026 Reset mid-word SHALL discard the in-flight word with no m_tvalid; operation SHALL resume on the first clk edge after rstn=1.

Structure
REQ-027 Package hsi_pkg SHALL hold the state enum, the CH_W computation, and parameter legal-range constants.
REQ-028 Round-robin grant SHALL be sub-module hsi_rr_arb (params N; ports req, advance, grant one-hot, grant_idx).
REQ-029 The bit/half-bit timing counter and shift registers SHALL remain in hsi_lane_engine.

Verification (NUM_TX=3, DATA_W=8, DIV=2 -> CH_W=2, word time 45 cycles)
REQ-030 Ch1 sends 0xA5, hs_rx looped to hs_tx -> hs_tx bits 0,1 then 1,0,1,0,0,1,0,1; 40 hs_frame cycles; m_tdata=0xA5 at GAP entry.
REQ-031 All three s_tvalid held high -> grants 0,1,2,0 with s_tready pulses 45 cycles apart.
REQ-032 m_tready=0, two words received -> first m_tdata kept, rx_overflow=1; m_tready=1 afterwards -> single transfer, rx_overflow stays 1.
REQ-033 cfg_enable dropped at cycle 10 of a word -> word completes through GAP, no further s_tready while cfg_enable=0.
REQ-034 rstn pulsed low at cycle 20 of a word -> all outputs 0 within that cycle, no m_tvalid; next grant starts at channel 0.

Source files
------------

// File: rtl/hsi_pkg.sv
// Shared types and sizing helpers for the HSI serial lane engine.
// Legal parameter ranges live here so every block agrees on them.
package hsi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    GAP
  } state_t;

  localparam int NUM_TX_MIN = 1;
  localparam int NUM_TX_MAX = 8;
  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 64;
  localparam int DIV_MIN    = 1;
  localparam int DIV_MAX    = 255;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hsi_rr_arb.sv
// Round-robin channel arbiter for the HSI lane engine.
// The pointer moves past the winner only when a grant is taken.
module hsi_rr_arb
  import hsi_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = ch_w(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        grant[(int'(ptr) + i) % N] = 1'b1;
        grant_idx = IW'((int'(ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0
           : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/hsi_lane_engine.sv
// Serial lane engine: arbitrates TX streams onto a framed serial
// link and captures the looped-back data word into an RX stream.
module hsi_lane_engine
  import hsi_pkg::*;
#(
  parameter int NUM_TX = 3,
  parameter int DATA_W = 32,
  parameter int DIV    = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cfg_enable,
  input  logic [NUM_TX*DATA_W-1:0] s_tdata,
  input  logic [NUM_TX-1:0]        s_tvalid,
  output logic [NUM_TX-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     hs_clk,
  output logic                     hs_frame,
  output logic                     hs_tx,
  input  logic                     hs_rx,
  output logic                     busy,
  output logic                     rx_overflow
);

  localparam int CH_W = ch_w(NUM_TX);
  localparam int NB   = CH_W + DATA_W;
  localparam int CW   = $clog2(2 * DIV);
  localparam int BW   = $clog2(NB);

  localparam logic [CW-1:0] HALF     = CW'(DIV);
  localparam logic [CW-1:0] HALF_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] LAST     = CW'(2 * DIV - 1);
  localparam logic [BW-1:0] HDR_LAST = BW'(CH_W - 1);
  localparam logic [BW-1:0] NB_LAST  = BW'(NB - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bitn;
  logic [NB-1:0]       sr;
  logic [DATA_W-1:0]   rx_sr;
  logic [DATA_W-1:0]   rx_next;
  logic [DATA_W-1:0]   sel;
  logic [NUM_TX-1:0]   grant;
  logic [CH_W-1:0]     grant_idx;
  logic                go;
  logic                bit_end;
  logic                sample;

  // rstn gates the grant so s_tready is low while reset is held
  assign go = rstn && (state == IDLE) && cfg_enable && (|s_tvalid);
  assign s_tready = go ? grant : '0;
  assign busy     = (state != IDLE);
  assign bit_end  = (cnt == LAST);
  assign sample   = (state == DATA) && (cnt == HALF);
  assign rx_next  = sample ? {rx_sr[DATA_W-2:0], hs_rx} : rx_sr;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_TX; i++) begin
      if (grant[i]) sel = sel | s_tdata[i*DATA_W +: DATA_W];
    end
  end

  hsi_rr_arb #(
    .N(NUM_TX)
  ) u_arb (
    .clk      (clk),
    .rstn     (rstn),
    .req      (s_tvalid),
    .advance  (go),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      bitn        <= '0;
      sr          <= '0;
      rx_sr       <= '0;
      m_tdata     <= '0;
      m_tvalid    <= 1'b0;
      rx_overflow <= 1'b0;
      hs_clk      <= 1'b0;
      hs_frame    <= 1'b0;
      hs_tx       <= 1'b0;
    end else begin
      if (m_tvalid && m_tready) m_tvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state    <= HDR;
            cnt      <= '0;
            bitn     <= '0;
            sr       <= {grant_idx, sel};
            hs_frame <= 1'b1;
            hs_tx    <= grant_idx[CH_W-1];
          end
        end
        HDR, DATA: begin
          rx_sr <= rx_next;
          if (bit_end) begin
            cnt    <= '0;
            hs_clk <= 1'b0;
            bitn   <= bitn + BW'(1);
            sr     <= {sr[NB-2:0], 1'b0};
            if (bitn == NB_LAST) begin
              state    <= GAP;
              hs_frame <= 1'b0;
              hs_tx    <= 1'b0;
              // a still-pending word blocks the load; the new one is lost
              if (!m_tvalid || m_tready) begin
                m_tdata  <= rx_next;
                m_tvalid <= 1'b1;
              end else begin
                rx_overflow <= 1'b1;
              end
            end else begin
              hs_tx <= sr[NB-2];
              if (bitn == HDR_LAST) state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == HALF_M1) hs_clk <= 1'b1;
          end
        end
        GAP: begin
          if (bit_end) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hsi_lane_engine.sv
// Scoreboard bench for hsi_lane_engine with hs_rx looped to hs_tx.
// NUM_TX=3, DATA_W=8, DIV=2: 40-cycle frame, 45-cycle word time.
module tb_hsi_lane_engine;

  localparam int NT    = 3;
  localparam int DW    = 8;
  localparam int DV    = 2;
  localparam int SW    = 10;
  localparam int FRAME = 40;
  localparam int WORD  = 45;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           cfg_enable = 1'b0;
  logic [NT*DW-1:0] s_tdata = '0;
  logic [NT-1:0]  s_tvalid = '0;
  logic [NT-1:0]  s_tready;
  logic [DW-1:0]  m_tdata;
  logic           m_tvalid;
  logic           m_tready = 1'b0;
  logic           hs_clk, hs_frame, hs_tx, hs_rx;
  logic           busy, rx_overflow;

  assign hs_rx = hs_tx;

  hsi_lane_engine #(
    .NUM_TX(NT),
    .DATA_W(DW),
    .DIV   (DV)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_enable (cfg_enable),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .hs_clk     (hs_clk),
    .hs_frame   (hs_frame),
    .hs_tx      (hs_tx),
    .hs_rx      (hs_rx),
    .busy       (busy),
    .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] src_q [NT][$];
  logic [DW-1:0] cur [NT];
  logic [NT-1:0] taken = '0;
  int            exp_grant [$];
  logic [SW-1:0] exp_ser [$];
  logic [DW-1:0] exp_rx [$];

  int            cyc = 0;
  int            n_grant = 0;
  int            last_g = -1;
  bit            gap_chk = 1'b0;
  int            frame_cnt = 0;
  int            nbits = 0;
  logic [SW-1:0] shreg = '0;
  logic          prev_frame = 1'b0;
  logic          prev_clk = 1'b0;
  logic          mdl_valid = 1'b0;
  logic          mdl_ovf = 1'b0;

  // Runs at negedge: inputs and outputs here are what the next posedge sees.
  task automatic monitor();
    logic gap_next;
    cyc++;
    chk("m_tvalid", m_tvalid, mdl_valid);
    chk("rx_overflow", rx_overflow, mdl_ovf);
    if (!hs_frame) chk("idle_lines", {hs_clk, hs_tx}, 2'b00);
    if (m_tvalid && m_tready) begin
      if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
      else chk("m_tdata", m_tdata, exp_rx.pop_front());
    end
    if (hs_frame) begin
      frame_cnt++;
      if (hs_clk && !prev_clk) begin
        shreg = {shreg[SW-2:0], hs_tx};
        nbits++;
      end
    end
    if (prev_frame && !hs_frame) begin
      chk("frame_len", frame_cnt, FRAME);
      chk("frame_bits", nbits, SW);
      if (exp_ser.size() == 0) chk("frame_unexpected", 1, 0);
      else chk("hs_tx_word", shreg, exp_ser.pop_front());
      frame_cnt = 0;
      nbits = 0;
      shreg = '0;
    end
    gap_next = hs_frame && (frame_cnt == FRAME);
    if (gap_next && exp_ser.size() > 0) begin
      if (!mdl_valid || m_tready) begin
        mdl_valid = 1'b1;
        exp_rx.push_back(exp_ser[0][DW-1:0]);
      end else begin
        mdl_ovf = 1'b1;
      end
    end else if (mdl_valid && m_tready) begin
      mdl_valid = 1'b0;
    end
    if (s_tready != '0) chk("tready_onehot", $countones(s_tready), 1);
    for (int i = 0; i < NT; i++) begin
      if (s_tready[i]) begin
        chk("tready_valid", s_tvalid[i], 1);
        if (exp_grant.size() == 0) chk("grant_unexpected", i, 99);
        else chk("grant_ch", i, exp_grant.pop_front());
        if (gap_chk && last_g >= 0) chk("grant_gap", cyc - last_g, WORD);
        last_g = cyc;
        n_grant++;
        exp_ser.push_back({2'(i), cur[i]});
        taken[i] = 1'b1;
      end
    end
    prev_frame = hs_frame;
    prev_clk = hs_clk;
  endtask

  task automatic apply_src();
    for (int i = 0; i < NT; i++) begin
      if (taken[i] || !s_tvalid[i]) begin
        taken[i] = 1'b0;
        if (src_q[i].size() > 0) begin
          cur[i] = src_q[i].pop_front();
          s_tvalid[i] = 1'b1;
          s_tdata[i*DW +: DW] = cur[i];
        end else begin
          s_tvalid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    apply_src();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_grants(input int target, input int budget);
    int b = 0;
    while (n_grant < target && b < budget) begin
      tick();
      b++;
    end
    if (n_grant < target) chk("grant_timeout", n_grant, target);
  endtask

  initial begin
    logic [DW-1:0] w0, w1;
    int g0;

    cfg_enable = 1'b1;
    s_tvalid = '1;
    #12;
    chk("rst_ready", s_tready, 0);
    chk("rst_lines", {hs_clk, hs_frame, hs_tx, busy}, 0);
    chk("rst_rx", {m_tvalid, rx_overflow}, 0);
    chk("rst_data", m_tdata, 0);
    s_tvalid = '0;
    run(2);
    rstn = 1'b1;

    // all three channels held valid: 0,1,2,0,1,2 back to back
    m_tready = 1'b1;
    gap_chk = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NT; i++) begin
        src_q[i].push_back(DW'($urandom));
        exp_grant.push_back(i);
      end
    end
    wait_grants(n_grant + 6, 400);
    run(50);

    // single word on channel 1
    gap_chk = 1'b0;
    src_q[1].push_back(8'hA5);
    exp_grant.push_back(1);
    wait_grants(n_grant + 1, 100);
    run(50);

    // sink stalled: second word dropped, overflow sticks
    m_tready = 1'b0;
    w0 = DW'($urandom);
    w1 = ~w0;
    src_q[2].push_back(w0);
    src_q[0].push_back(w1);
    exp_grant.push_back(2);
    exp_grant.push_back(0);
    wait_grants(n_grant + 2, 200);
    run(50);
    chk("keep_first", m_tdata, w0);
    chk("ovf_set", rx_overflow, 1);
    m_tready = 1'b1;
    run(5);
    chk("drain_once", exp_rx.size(), 0);
    chk("mvalid_clear", m_tvalid, 0);

    // cfg_enable dropped mid-word
    g0 = n_grant;
    src_q[1].push_back(DW'($urandom));
    exp_grant.push_back(1);
    wait_grants(g0 + 1, 100);
    run(9);
    cfg_enable = 1'b0;
    src_q[2].push_back(DW'($urandom));
    run(90);
    chk("no_grant_off", n_grant, g0 + 1);
    chk("idle_off", busy, 0);
    cfg_enable = 1'b1;
    exp_grant.push_back(2);
    wait_grants(g0 + 2, 20);
    run(50);

    // reset mid-word
    src_q[1].push_back(DW'($urandom));
    exp_grant.push_back(1);
    wait_grants(n_grant + 1, 100);
    run(19);
    src_q[0].push_back(DW'($urandom));
    src_q[2].push_back(DW'($urandom));
    run(1);
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", s_tready, 0);
    chk("mid_rst_lines", {hs_clk, hs_frame, hs_tx, busy}, 0);
    chk("mid_rst_rx", {m_tvalid, rx_overflow}, 0);
    chk("mid_rst_data", m_tdata, 0);
    exp_ser.delete();
    exp_grant.delete();
    frame_cnt = 0;
    nbits = 0;
    shreg = '0;
    prev_frame = 1'b0;
    prev_clk = 1'b0;
    mdl_valid = 1'b0;
    mdl_ovf = 1'b0;
    last_g = -1;
    gap_chk = 1'b1;
    exp_grant.push_back(0);
    exp_grant.push_back(2);
    run(3);
    rstn = 1'b1;
    wait_grants(n_grant + 2, 200);
    run(50);

    chk("sb_empty", exp_grant.size() + exp_ser.size() + exp_rx.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
